// File: rtl/food_spawn_ctrl.sv
// rtl/food_spawn_ctrl.sv - LFSR-driven food placement with off-grid/occupancy rejection and bounded retries
module food_spawn_ctrl #(
    parameter int                LFSR_W    = 16,
    parameter int                X_BITS    = 5,
    parameter int                Y_BITS    = 5,
    parameter int                GRID_W    = 30,
    parameter int                GRID_H    = 20,
    parameter int                MAX_TRIES = 64,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spawn_req,
    input  logic [LFSR_W-1:0] lfsr_val,
    output logic              lfsr_en,
    output logic              lfsr_load,
    output logic [LFSR_W-1:0] lfsr_seed,
    output logic              occ_rd,
    output logic [X_BITS-1:0] occ_x,
    output logic [Y_BITS-1:0] occ_y,
    input  logic              occ_hit,
    output logic              busy,
    output logic              food_valid,
    output logic              spawn_fail,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y
);

    localparam int                TRY_W       = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]  MAX_TRIES_L = TRY_W'(MAX_TRIES);
    localparam logic [X_BITS:0]   GRID_W_L    = (X_BITS + 1)'(GRID_W);
    localparam logic [Y_BITS:0]   GRID_H_L    = (Y_BITS + 1)'(GRID_H);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_STEP,
        S_CHECK,
        S_WAIT
    } state_t;

    state_t             state, state_next;
    logic [TRY_W-1:0]   tries, tries_next;
    logic               busy_d, lfsr_en_d, lfsr_load_d, occ_rd_d;
    logic               food_valid_d, spawn_fail_d, reject;
    logic [X_BITS-1:0]  occ_x_d, food_x_d, xc;
    logic [Y_BITS-1:0]  occ_y_d, food_y_d, yc;
    logic               in_range;

    assign lfsr_seed = SEED;
    assign xc        = lfsr_val[X_BITS-1:0];
    assign yc        = lfsr_val[X_BITS+Y_BITS-1:X_BITS];
    assign in_range  = ({1'b0, xc} < GRID_W_L) && ({1'b0, yc} < GRID_H_L);

    generate
        if (X_BITS + Y_BITS < LFSR_W) begin : g_spare_bits
            logic unused_lfsr_bits;
            assign unused_lfsr_bits = ^lfsr_val[LFSR_W-1:X_BITS+Y_BITS];
        end
    endgenerate

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_next   = state;
        tries_next   = tries;
        busy_d       = busy;
        lfsr_en_d    = 1'b0;
        lfsr_load_d  = 1'b0;
        occ_rd_d     = 1'b0;
        occ_x_d      = occ_x;
        occ_y_d      = occ_y;
        food_valid_d = 1'b0;
        spawn_fail_d = 1'b0;
        food_x_d     = food_x;
        food_y_d     = food_y;
        reject       = 1'b0;

        case (state)
            S_INIT: begin
                lfsr_load_d = 1'b1;
                busy_d      = 1'b1;
                state_next  = S_IDLE;
            end
            S_IDLE: begin
                busy_d = 1'b0;
                if (spawn_req) begin
                    tries_next = '0;
                    busy_d     = 1'b1;
                    lfsr_en_d  = 1'b1;
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                tries_next = tries + TRY_W'(1);
                state_next = S_CHECK;
            end
            S_CHECK: begin
                if (in_range) begin
                    occ_x_d    = xc;
                    occ_y_d    = yc;
                    occ_rd_d   = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    reject = 1'b1;
                end
            end
            S_WAIT: begin
                if (!occ_hit) begin
                    food_x_d     = occ_x;
                    food_y_d     = occ_y;
                    food_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_next   = S_IDLE;
                end else begin
                    reject = 1'b1;
                end
            end
            default: state_next = S_INIT;
        endcase

        // tries already counts the candidate just rejected
        if (reject) begin
            if (tries < MAX_TRIES_L) begin
                lfsr_en_d  = 1'b1;
                state_next = S_STEP;
            end else begin
                spawn_fail_d = 1'b1;
                busy_d       = 1'b0;
                state_next   = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_INIT;
            tries      <= '0;
            busy       <= 1'b0;
            lfsr_en    <= 1'b0;
            lfsr_load  <= 1'b0;
            occ_rd     <= 1'b0;
            occ_x      <= '0;
            occ_y      <= '0;
            food_valid <= 1'b0;
            spawn_fail <= 1'b0;
            food_x     <= '0;
            food_y     <= '0;
        end else begin
            state      <= state_next;
            tries      <= tries_next;
            busy       <= busy_d;
            lfsr_en    <= lfsr_en_d;
            lfsr_load  <= lfsr_load_d;
            occ_rd     <= occ_rd_d;
            occ_x      <= occ_x_d;
            occ_y      <= occ_y_d;
            food_valid <= food_valid_d;
            spawn_fail <= spawn_fail_d;
            food_x     <= food_x_d;
            food_y     <= food_y_d;
        end
    end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// tb/tb_food_spawn_ctrl.sv - scoreboard bench for food_spawn_ctrl with LFSR and occupancy models
module tb_food_spawn_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spawn_req = 1'b0;
    logic [15:0] lfsr_val = 16'h0000;
    logic        occ_hit = 1'b0;
    logic        lfsr_en, lfsr_load, occ_rd, busy, food_valid, spawn_fail;
    logic [15:0] lfsr_seed;
    logic [4:0]  occ_x, occ_y, food_x, food_y;

    always #5 clk = ~clk;

    food_spawn_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spawn_req  (spawn_req),
        .lfsr_val   (lfsr_val),
        .lfsr_en    (lfsr_en),
        .lfsr_load  (lfsr_load),
        .lfsr_seed  (lfsr_seed),
        .occ_rd     (occ_rd),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_hit    (occ_hit),
        .busy       (busy),
        .food_valid (food_valid),
        .spawn_fail (spawn_fail),
        .food_x     (food_x),
        .food_y     (food_y)
    );

    typedef struct {
        bit         fail;
        logic [4:0] x;
        logic [4:0] y;
        int         lat;
        int         t0;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] lfsr_q[$];
    bit          occ_q[$];
    bit          occ_default = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          en_cnt = 0, rd_cnt = 0, load_cnt = 0, pulse_cnt = 0, busy_gap = 0;
    logic [4:0]  last_occ_x = '0, last_occ_y = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (lfsr_load) lfsr_val <= lfsr_seed;
        else if (lfsr_en) begin
            if (lfsr_q.size() > 0) lfsr_val <= lfsr_q.pop_front();
            else lfsr_val <= 16'h0025;
        end
    end

    // Occupancy map answers while occ_rd is up; the DUT samples it on the next edge.
    always @(negedge clk) begin
        if (occ_rd) begin
            rd_cnt++;
            last_occ_x = occ_x;
            last_occ_y = occ_y;
            if (occ_q.size() > 0) occ_hit = occ_q.pop_front();
            else occ_hit = occ_default;
        end else begin
            occ_hit = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (lfsr_en) en_cnt++;
        if (lfsr_load) load_cnt++;
        if (lfsr_en && lfsr_load) chk("en_load_overlap", {30'd0, lfsr_en, lfsr_load}, 32'd2);
        if (food_valid || spawn_fail) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, food_valid, spawn_fail}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", {30'd0, food_valid, spawn_fail}, e.fail ? 32'd1 : 32'd2);
                chk("food_x", {27'd0, food_x}, {27'd0, e.x});
                chk("food_y", {27'd0, food_y}, {27'd0, e.y});
                chk("latency", cyc - e.t0, e.lat);
                chk("busy_at_pulse", {31'd0, busy}, 32'd0);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].t0 && !busy) begin
            busy_gap++;
        end
    end

    task automatic request(input bit f, input logic [4:0] x, input logic [4:0] y,
                           input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        spawn_req = 1'b1;
        if (push) begin
            e.fail = f; e.x = x; e.y = y; e.lat = lat; e.t0 = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        spawn_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("completion_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int e0, r0, g0, l0, p0, n;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {26'd0, busy, lfsr_en, lfsr_load, occ_rd, food_valid, spawn_fail}, 32'd0);
        chk("rst_food", {22'd0, food_x, food_y}, 32'd0);
        chk("rst_occ", {22'd0, occ_x, occ_y}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_load", {31'd0, lfsr_load}, 32'd1);
        chk("init_seed", {16'd0, lfsr_seed}, 32'hACE1);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("load_once", load_cnt, 1);
        chk("no_step_at_init", en_cnt, 0);

        lfsr_q = '{16'h0025}; occ_q = '{1'b0};
        e0 = en_cnt; r0 = rd_cnt;
        request(1'b0, 5'd5, 5'd1, 4, 1'b1);
        wait_done(50);
        chk("first_try_steps", en_cnt - e0, 1);
        chk("first_try_reads", rd_cnt - r0, 1);
        chk("first_try_occ", {22'd0, last_occ_x, last_occ_y}, {22'd0, 5'd5, 5'd1});

        lfsr_q = '{16'h001F, 16'h0280, 16'h0043}; occ_q = '{1'b0};
        e0 = en_cnt; r0 = rd_cnt;
        request(1'b0, 5'd3, 5'd2, 8, 1'b1);
        wait_done(50);
        chk("range_steps", en_cnt - e0, 3);
        chk("range_reads", rd_cnt - r0, 1);

        lfsr_q = '{16'h0025, 16'h0067}; occ_q = '{1'b1, 1'b0};
        e0 = en_cnt; r0 = rd_cnt; g0 = busy_gap;
        request(1'b0, 5'd7, 5'd3, 7, 1'b1);
        wait_done(50);
        chk("occ_steps", en_cnt - e0, 2);
        chk("occ_reads", rd_cnt - r0, 2);
        chk("occ_busy_gap", busy_gap - g0, 0);
        chk("occ_last", {22'd0, last_occ_x, last_occ_y}, {22'd0, 5'd7, 5'd3});

        occ_default = 1'b1;
        e0 = en_cnt; r0 = rd_cnt; p0 = pulse_cnt;
        request(1'b1, 5'd7, 5'd3, 193, 1'b1);
        wait_done(400);
        repeat (5) @(negedge clk);
        chk("exhaust_steps", en_cnt - e0, 64);
        chk("exhaust_reads", rd_cnt - r0, 64);
        chk("exhaust_pulses", pulse_cnt - p0, 1);
        occ_default = 1'b0;

        lfsr_q = '{16'h0025}; occ_q = '{1'b0};
        e0 = en_cnt; p0 = pulse_cnt;
        request(1'b0, 5'd5, 5'd1, 4, 1'b1);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        wait_done(50);
        repeat (10) @(negedge clk);
        chk("busy_req_steps", en_cnt - e0, 1);
        chk("busy_req_pulses", pulse_cnt - p0, 1);

        lfsr_q = '{16'h0025}; occ_q = '{1'b0};
        request(1'b0, 5'd0, 5'd0, 0, 1'b0);
        n = 0;
        while (!occ_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait", {31'd0, occ_rd}, 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        l0 = load_cnt; p0 = pulse_cnt;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_reseed", load_cnt - l0, 1);
        chk("abort_no_pulse", pulse_cnt - p0, 0);
        chk("abort_idle", {21'd0, busy, food_x, food_y}, 32'd0);

        request(1'b0, 5'd5, 5'd1, 4, 1'b1);
        wait_done(50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/food_spawn_ctrl.md
Name: food_spawn_ctrl

Overview:
- Sequences the 16-bit LFSR to place a new food item on the snake playfield.
- On a spawn request, the block steps the LFSR and maps its bits to an (x,y) candidate.
- It rejects candidates that fall off-grid or that the occupancy lookup reports as occupied, and retries up to a bounded count.
- It sits between the game-control FSM, the LFSR and the snake occupancy map.

Parameters:
- LFSR_W, 16, LFSR state width.
- X_BITS, 5, width of the x coordinate.
- Y_BITS, 5, width of the y coordinate (X_BITS+Y_BITS <= LFSR_W).
- GRID_W, 30, legal x range is 0..GRID_W-1.
- GRID_H, 20, legal y range is 0..GRID_H-1.
- MAX_TRIES, 64, candidate attempts per request before giving up.
- SEED, 16'hACE1, nonzero value loaded into the LFSR after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- spawn_req  in  1  single-cycle request for a new food position.
- lfsr_val  in  LFSR_W  current LFSR state.
- lfsr_en  out  1  advances the LFSR by one step.
- lfsr_load  out  1  loads lfsr_seed into the LFSR.
- lfsr_seed  out  LFSR_W  constant SEED.
- occ_rd  out  1  occupancy lookup strobe.
- occ_x  out  X_BITS  lookup x.
- occ_y  out  Y_BITS  lookup y.
- occ_hit  in  1  cell occupied; valid exactly 1 cycle after occ_rd.
- busy  out  1  request in progress.
- food_valid  out  1  one-cycle pulse: new position is ready.
- spawn_fail  out  1  one-cycle pulse: tries exhausted.
- food_x  out  X_BITS  last accepted food x (held).
- food_y  out  Y_BITS  last accepted food y (held).

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clock edge):
  - State goes to INIT; try count is 0.
  - busy, lfsr_en, occ_rd, food_valid and spawn_fail are 0.
  - food_x, food_y, occ_x and occ_y are 0.
  - Reset asserted mid-request aborts the request silently; no food_valid or spawn_fail pulse is issued.
- INIT: lfsr_load=1 for exactly one cycle, then go to IDLE. busy=1 during INIT.
- IDLE: busy=0. When spawn_req=1, clear the try count and go to STEP. spawn_req in any other state is ignored and is not queued.
- STEP: lfsr_en=1 for one cycle and the try count increments. Go to CHECK.
- CHECK: sample lfsr_val and form the candidate:
  - xc = lfsr_val[X_BITS-1:0]
  - yc = lfsr_val[X_BITS+Y_BITS-1:X_BITS]
  - If xc>=GRID_W or yc>=GRID_H, the candidate is rejected.
  - If the candidate is in range: occ_x=xc, occ_y=yc, occ_rd=1 for one cycle, then go to WAIT.
- WAIT: sample occ_hit.
  - occ_hit=0: food_x=xc, food_y=yc, food_valid=1 for one cycle, return to IDLE.
  - occ_hit=1: the candidate is rejected.
- On any rejection:
  - If try count < MAX_TRIES, go to STEP.
  - Otherwise go to IDLE with spawn_fail=1 for one cycle. food_x and food_y are unchanged.
- Latency, measured from the clock edge that samples spawn_req:
  - Success on the first try: food_valid is high in cycle 4 (STEP 1, CHECK 2, WAIT 3, pulse 4).
  - Each off-grid retry adds 2 cycles; each occupied retry adds 3 cycles.
- busy=1 from the cycle after spawn_req is sampled until the cycle the food_valid or spawn_fail pulse is asserted; busy=0 in that cycle.
- food_valid and spawn_fail are mutually exclusive and never high for 2 consecutive cycles.
- lfsr_en and lfsr_load are never high together. lfsr_en is high only in STEP.
- Once the MAX_TRIES-th candidate is rejected, the block issues no further lfsr_en pulses.
- Coordinate comparisons use unsigned arithmetic. The try counter is wide enough to hold MAX_TRIES without wrap-around.

Test Plan:
1. Reset release: lfsr_load is high for exactly 1 cycle with lfsr_seed=16'hACE1; busy is low from cycle 2 on; no lfsr_en pulses.
2. First-try success: spawn_req with the bench LFSR yielding 16'h0025 and occ_hit=0 -> occ_rd with occ_x=5, occ_y=1; food_valid 4 cycles after the request; food_x=5, food_y=1; exactly 1 lfsr_en pulse.
3. Range rejection: LFSR yields 16'h001F (x=31), then 16'h0280 (y=20), then 16'h0043 -> 3 lfsr_en pulses; no occ_rd for the first two; food = (3,2); food_valid at cycle 8.
4. Occupied retry: first candidate (5,1) with occ_hit=1, second candidate (7,3) free -> 2 occ_rd pulses; food = (7,3) at cycle 7; busy high throughout.
5. Exhaustion: occ_hit tied to 1 with in-range values -> exactly 64 lfsr_en pulses; spawn_fail pulse; food_x/food_y keep their previous values; food_valid never asserted.
6. Abuse cases:
   - spawn_req pulsed while busy -> ignored; exactly one completion.
   - rst_n low during WAIT -> no pulse, INIT reseed.
